// File: rtl/attex_bus_sequencer.sv
// Registered bus-cycle controller between the SCC68070 and the ATTEX peripherals.
// Define ATTEX_BUS_TIMEOUT_EN to end unanswered target cycles with a timeout bus error.
module attex_bus_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk30,
  input  logic        reset,
  input  logic        as,
  input  logic        uds,
  input  logic        lds,
  input  logic        write_strobe,
  input  logic [23:1] addr,
  input  logic        iack4,
  input  logic        ack_mcd,
  input  logic        ack_cdic,
  input  logic        ack_slave,
  input  logic        ack_mk48,
  input  logic [15:0] dout_mcd,
  input  logic [15:0] dout_cdic,
  input  logic [7:0]  dout_slave,
  input  logic [7:0]  dout_mk48,
  output logic        cs_mcd,
  output logic        cs_dvc,
  output logic        cs_cdic,
  output logic        cs_slave,
  output logic        cs_mk48,
  output logic        bus_ack,
  output logic        bus_err,
  output logic [15:0] data_in,
  output logic [23:0] err_addr,
  output logic        err_timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in [2, 65536]");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WAIT_ACK, S_DONE, S_FAULT, S_HOLD
  } state_e;

  typedef enum logic [2:0] {
    R_OPEN, R_ERR, R_MCD, R_DVC, R_CDIC, R_SLAVE, R_MK48
  } region_e;

  typedef struct packed {
    logic mcd;
    logic dvc;
    logic cdic;
    logic slave;
    logic mk48;
  } cs_t;

  state_e      state, state_next;
  region_e     region;
  cs_t         cs_q, cs_next;
  logic [23:0] a_q;
  logic        wr_q, uds_q, lds_q;
  logic        bus_ack_next, bus_err_next, err_timeout_next;
  logic [15:0] data_in_next;
  logic [23:0] err_addr_next;
  logic        sel_ack;
  logic [15:0] sel_data;
  logic        timeout_hit;

  // Address decode on the latched byte address; earlier branches win.
  always_comb begin
    region = R_OPEN;
    if (((a_q >= 24'h080000 && a_q < 24'h200000) ||
         (a_q >= 24'h500000 && a_q < 24'hd00000) ||
         (a_q >= 24'hf00000)) && (uds_q || lds_q))
      region = R_ERR;
    else if (a_q[23:16] == 8'h30)
      region = R_CDIC;
    else if (a_q[23:16] == 8'h31)
      region = R_SLAVE;
    else if (a_q[23:16] == 8'h32)
      region = R_MK48;
    else if (a_q[23:20] == 4'hd || a_q[23:19] == 5'b11101)
      region = R_DVC;
    else if ((a_q <= 24'h27ffff || a_q >= 24'h400000) && !a_q[23])
      region = R_MCD;
  end

  // MCD212 and DVC RAM share one acknowledge and data path; byte targets drive both lanes.
  always_comb begin
    sel_ack  = 1'b0;
    sel_data = 16'h0000;
    if (cs_q.mcd || cs_q.dvc) begin
      sel_ack  = ack_mcd;
      sel_data = dout_mcd;
    end else if (cs_q.cdic) begin
      sel_ack  = ack_cdic;
      sel_data = dout_cdic;
    end else if (cs_q.slave) begin
      sel_ack  = ack_slave;
      sel_data = {dout_slave, dout_slave};
    end else if (cs_q.mk48) begin
      sel_ack  = ack_mk48;
      sel_data = {dout_mk48, dout_mk48};
    end
  end

`ifdef ATTEX_BUS_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;

  // Held at zero outside WAIT_ACK so every entry starts counting from zero.
  always_ff @(posedge clk30) begin
    if (reset || state != S_WAIT_ACK)
      wait_cnt <= '0;
    else if (wait_cnt != 16'hffff)
      wait_cnt <= wait_cnt + 16'd1;
  end

  assign timeout_hit = (wait_cnt == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_next       = state;
    cs_next          = '0;
    bus_ack_next     = 1'b0;
    bus_err_next     = 1'b0;
    data_in_next     = data_in;
    err_addr_next    = err_addr;
    err_timeout_next = err_timeout;
    unique case (state)
      S_IDLE: begin
        if (as) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (!as) begin
          state_next = S_IDLE;
        end else if (iack4) begin
          state_next   = S_DONE;
          bus_ack_next = 1'b1;
          if (!wr_q) data_in_next = dout_cdic;
        end else begin
          unique case (region)
            R_ERR: begin
              state_next       = S_FAULT;
              bus_err_next     = 1'b1;
              err_addr_next    = a_q;
              err_timeout_next = 1'b0;
            end
            R_OPEN: begin
              state_next   = S_DONE;
              bus_ack_next = 1'b1;
              if (!wr_q) data_in_next = 16'h0000;
            end
            R_MCD:   begin cs_next.mcd   = 1'b1; state_next = S_WAIT_ACK; end
            R_DVC:   begin cs_next.dvc   = 1'b1; state_next = S_WAIT_ACK; end
            R_CDIC:  begin cs_next.cdic  = 1'b1; state_next = S_WAIT_ACK; end
            R_SLAVE: begin cs_next.slave = 1'b1; state_next = S_WAIT_ACK; end
            R_MK48:  begin cs_next.mk48  = 1'b1; state_next = S_WAIT_ACK; end
            default: state_next = S_IDLE;
          endcase
        end
      end
      S_WAIT_ACK: begin
        if (!as) begin
          state_next = S_IDLE;
        end else if (sel_ack) begin
          state_next   = S_DONE;
          bus_ack_next = 1'b1;
          if (!wr_q) data_in_next = sel_data;
        end else if (timeout_hit) begin
          state_next       = S_FAULT;
          bus_err_next     = 1'b1;
          err_addr_next    = a_q;
          err_timeout_next = 1'b1;
        end else begin
          cs_next = cs_q;
        end
      end
      S_DONE, S_FAULT: state_next = S_HOLD;
      S_HOLD: begin
        if (!as) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk30) begin
    if (reset) begin
      state       <= S_IDLE;
      cs_q        <= '0;
      bus_ack     <= 1'b0;
      bus_err     <= 1'b0;
      data_in     <= 16'h0000;
      err_addr    <= 24'h000000;
      err_timeout <= 1'b0;
      a_q         <= 24'h000000;
      wr_q        <= 1'b0;
      uds_q       <= 1'b0;
      lds_q       <= 1'b0;
    end else begin
      state       <= state_next;
      cs_q        <= cs_next;
      bus_ack     <= bus_ack_next;
      bus_err     <= bus_err_next;
      data_in     <= data_in_next;
      err_addr    <= err_addr_next;
      err_timeout <= err_timeout_next;
      if (state == S_IDLE && as) begin
        a_q   <= {addr, 1'b0};
        wr_q  <= write_strobe;
        uds_q <= uds;
        lds_q <= lds;
      end
    end
  end

  assign cs_mcd   = cs_q.mcd;
  assign cs_dvc   = cs_q.dvc;
  assign cs_cdic  = cs_q.cdic;
  assign cs_slave = cs_q.slave;
  assign cs_mk48  = cs_q.mk48;

endmodule

// File: tb/tb_attex_bus_sequencer.sv
// Directed bench for attex_bus_sequencer: decode, ack timing, data latching, faults, abort and reset.
module tb_attex_bus_sequencer;

  logic        clk30 = 1'b0;
  logic        reset, as, uds, lds, write_strobe, iack4;
  logic [23:1] addr;
  logic        ack_mcd, ack_cdic, ack_slave, ack_mk48;
  logic [15:0] dout_mcd, dout_cdic;
  logic [7:0]  dout_slave, dout_mk48;
  logic        cs_mcd, cs_dvc, cs_cdic, cs_slave, cs_mk48;
  logic        bus_ack, bus_err, err_timeout;
  logic [15:0] data_in;
  logic [23:0] err_addr;
  logic [4:0]  cs_all;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] CS_NONE  = 5'b00000;
  localparam logic [4:0] CS_MCD   = 5'b10000;
  localparam logic [4:0] CS_DVC   = 5'b01000;
  localparam logic [4:0] CS_CDIC  = 5'b00100;
  localparam logic [4:0] CS_SLAVE = 5'b00010;
  localparam logic [4:0] CS_MK48  = 5'b00001;

  always #5 clk30 = ~clk30;

  assign cs_all = {cs_mcd, cs_dvc, cs_cdic, cs_slave, cs_mk48};

  attex_bus_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk30(clk30), .reset(reset), .as(as), .uds(uds), .lds(lds),
    .write_strobe(write_strobe), .addr(addr), .iack4(iack4),
    .ack_mcd(ack_mcd), .ack_cdic(ack_cdic), .ack_slave(ack_slave), .ack_mk48(ack_mk48),
    .dout_mcd(dout_mcd), .dout_cdic(dout_cdic), .dout_slave(dout_slave), .dout_mk48(dout_mk48),
    .cs_mcd(cs_mcd), .cs_dvc(cs_dvc), .cs_cdic(cs_cdic), .cs_slave(cs_slave), .cs_mk48(cs_mk48),
    .bus_ack(bus_ack), .bus_err(bus_err), .data_in(data_in),
    .err_addr(err_addr), .err_timeout(err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk30);
    #1;
  endtask

  task automatic start(input logic [23:0] a, input logic wr, input logic u, input logic l);
    addr         = a[23:1];
    write_strobe = wr;
    uds          = u;
    lds          = l;
    as           = 1'b1;
  endtask

  task automatic finish_cycle();
    as = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; as = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0; iack4 = 1'b0;
    addr = '0; ack_mcd = 1'b0; ack_cdic = 1'b0; ack_slave = 1'b0; ack_mk48 = 1'b0;
    dout_mcd = 16'h0; dout_cdic = 16'h0; dout_slave = 8'h0; dout_mk48 = 8'h0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_cs", cs_all, CS_NONE);
    check("rst_ack", bus_ack, 1'b0);
    check("rst_err", bus_err, 1'b0);
    check("rst_data", data_in, 16'h0000);
    check("rst_err_addr", err_addr, 24'h0);
    check("rst_timeout", err_timeout, 1'b0);
    tick();

    // CDIC read, ack 3 cycles after cs; a stray slave ack must be ignored
    ack_slave = 1'b1; dout_slave = 8'hEE;
    start(24'h300000, 1'b0, 1'b1, 1'b1);
    tick();
    check("cdic_decode_cs", cs_all, CS_NONE);
    tick();
    check("cdic_cs", cs_all, CS_CDIC);
    tick(); tick(); tick();
    check("cdic_wait_ack", bus_ack, 1'b0);
    check("cdic_cs_held", cs_all, CS_CDIC);
    ack_cdic = 1'b1; dout_cdic = 16'h1234;
    tick();
    check("cdic_ack", bus_ack, 1'b1);
    check("cdic_data", data_in, 16'h1234);
    check("cdic_cs_drop", cs_all, CS_NONE);
    ack_cdic = 1'b0;
    tick();
    check("cdic_ack_single", bus_ack, 1'b0);
    ack_slave = 1'b0;
    finish_cycle();

    // MK48 byte read with ack already high on cs entry, then a write
    ack_mk48 = 1'b1; dout_mk48 = 8'h5A;
    start(24'h320002, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    check("mk48_cs", cs_all, CS_MK48);
    tick();
    check("mk48_ack", bus_ack, 1'b1);
    check("mk48_data", data_in, 16'h5A5A);
    tick();
    check("mk48_ack_single", bus_ack, 1'b0);
    finish_cycle();
    dout_mk48 = 8'h77;
    start(24'h320002, 1'b1, 1'b0, 1'b1);
    tick(); tick(); tick();
    check("mk48_wr_ack", bus_ack, 1'b1);
    check("mk48_wr_data", data_in, 16'h5A5A);
    ack_mk48 = 1'b0;
    finish_cycle();

    // Decode-region error
    start(24'h600000, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    check("err_pulse", bus_err, 1'b1);
    check("err_addr", err_addr, 24'h600000);
    check("err_cs", cs_all, CS_NONE);
    check("err_no_ack", bus_ack, 1'b0);
    tick();
    check("err_single", bus_err, 1'b0);
    finish_cycle();

    // Region boundaries: 1FFFFE faults, 200000 is MCD
    start(24'h1FFFFE, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    check("bnd_err", bus_err, 1'b1);
    check("bnd_err_addr", err_addr, 24'h1FFFFE);
    finish_cycle();
    ack_mcd = 1'b1; dout_mcd = 16'hBEEF;
    start(24'h200000, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    check("mcd_cs", cs_all, CS_MCD);
    tick();
    check("mcd_ack", bus_ack, 1'b1);
    check("mcd_data", data_in, 16'hBEEF);
    ack_mcd = 1'b0;
    finish_cycle();

    // OPEN region and CDIC interrupt acknowledge
    start(24'h2A0000, 1'b0, 1'b1, 1'b1);
    tick(); tick();
    check("open_ack", bus_ack, 1'b1);
    check("open_data", data_in, 16'h0000);
    check("open_cs", cs_all, CS_NONE);
    finish_cycle();
    iack4 = 1'b1; dout_cdic = 16'h0045;
    start(24'h2A0000, 1'b0, 1'b1, 1'b1);
    tick(); tick();
    check("iack_ack", bus_ack, 1'b1);
    check("iack_data", data_in, 16'h0045);
    iack4 = 1'b0;
    finish_cycle();

    // DVC select, then abort by dropping as in WAIT_ACK
    start(24'hE80000, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    check("dvc_cs", cs_all, CS_DVC);
    as = 1'b0;
    tick();
    check("abort_cs", cs_all, CS_NONE);
    check("abort_no_ack", bus_ack, 1'b0);
    check("abort_no_err", bus_err, 1'b0);
    tick();
    check("abort_data_kept", data_in, 16'h0045);
    finish_cycle();

    // Unanswered slave access
    start(24'h310000, 1'b0, 1'b1, 1'b1);
    tick(); tick();
    check("slave_cs", cs_all, CS_SLAVE);
`ifdef ATTEX_BUS_TIMEOUT_EN
    repeat (7) tick();
    check("to_not_yet", bus_err, 1'b0);
    check("to_cs_held", cs_all, CS_SLAVE);
    tick();
    check("to_err", bus_err, 1'b1);
    check("to_flag", err_timeout, 1'b1);
    check("to_err_addr", err_addr, 24'h310000);
    check("to_cs_drop", cs_all, CS_NONE);
    finish_cycle();
    start(24'h600000, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    check("to_clr_err", bus_err, 1'b1);
    check("to_clr_flag", err_timeout, 1'b0);
    finish_cycle();
`else
    repeat (20) tick();
    check("nto_no_err", bus_err, 1'b0);
    check("nto_cs_held", cs_all, CS_SLAVE);
    check("nto_flag", err_timeout, 1'b0);
    ack_slave = 1'b1; dout_slave = 8'h3C;
    tick();
    check("nto_ack", bus_ack, 1'b1);
    check("nto_data", data_in, 16'h3C3C);
    ack_slave = 1'b0;
    finish_cycle();
`endif

    // Reset in the middle of a WAIT_ACK
    start(24'h300000, 1'b0, 1'b1, 1'b1);
    tick(); tick();
    check("mid_cs", cs_all, CS_CDIC);
    reset = 1'b1;
    tick();
    check("mid_rst_cs", cs_all, CS_NONE);
    check("mid_rst_ack", bus_ack, 1'b0);
    check("mid_rst_err", bus_err, 1'b0);
    check("mid_rst_data", data_in, 16'h0000);
    check("mid_rst_err_addr", err_addr, 24'h0);
    check("mid_rst_timeout", err_timeout, 1'b0);
    reset = 1'b0; as = 1'b0;
    tick();
    check("post_rst_idle_cs", cs_all, CS_NONE);
    check("post_rst_idle_ack", bus_ack, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
